tensor_to_bitmap_reshaper: RTL

Inverse of the bitmap-to-tensor path. Accepts a planar tensor as three consecutive AXI-Stream packets on one input: R plane, then G plane, then B plane, each ending in tlast. It buffers all three planes and emits one packet of interleaved RGB bytes (R0 G0 B0 R1 G1 B1 …). It sits on the egress side, after tensor processing, and feeds the bitmap/packet output path.

---
 rtl/tensor_to_bitmap_reshaper_pkg.sv | 31 +++
 rtl/tensor_to_bitmap_reshaper_if.sv | 17 +
 rtl/tensor_to_bitmap_reshaper_plane.sv | 59 +++++
 rtl/tensor_to_bitmap_reshaper.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/tensor_to_bitmap_reshaper_pkg.sv
// Shared types and sizing helpers for the planar-tensor to interleaved-RGB reshaper.
package tensor_to_bitmap_reshaper_pkg;

  typedef enum logic [1:0] {
    LOAD_R = 2'd0,
    LOAD_G = 2'd1,
    LOAD_B = 2'd2,
    EMIT   = 2'd3
  } state_e;

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;
  localparam int NUM_CH = 3;

  localparam int DEF_MAX_PIXELS = 256;

  // Per-plane pixel count, saturating at max_pixels.
  function automatic int cnt_w(input int max_pixels);
    return $clog2(max_pixels + 1);
  endfunction

  // Interleaved output byte count (3 * pixels).
  function automatic int byte_cnt_w(input int max_pixels);
    return $clog2(3 * max_pixels + 1);
  endfunction

  localparam int DEF_CNT_W  = $clog2(DEF_MAX_PIXELS + 1);
  localparam int DEF_BYTE_W = $clog2(3 * DEF_MAX_PIXELS + 1);

endpackage

// File: rtl/tensor_to_bitmap_reshaper_if.sv
// AXI-Stream bundle used for both the planar input and the interleaved output.
interface tensor_to_bitmap_reshaper_if #(
  parameter int TDATA_WIDTH = 256,
  parameter int TUSER_WIDTH = 128
);
  localparam int TKEEP_WIDTH = TDATA_WIDTH / 8;

  logic [TDATA_WIDTH-1:0] tdata;
  logic [TKEEP_WIDTH-1:0] tkeep;
  logic [TUSER_WIDTH-1:0] tuser;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/tensor_to_bitmap_reshaper_plane.sv
// One channel plane: packs incoming bytes at the running count (saturating) and
// serves BPB byte-addressed reads that already see this cycle's write.
module tensor_plane_buffer
  import tensor_to_bitmap_reshaper_pkg::*;
#(
  parameter int BPB        = 32,
  parameter int MAX_PIXELS = 256,
  localparam int CW = cnt_w(MAX_PIXELS),
  localparam int AW = (MAX_PIXELS > 1) ? $clog2(MAX_PIXELS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic                   clr,
  input  logic [BPB*8-1:0]       wr_data,
  input  logic [BPB-1:0]         wr_keep,
  input  logic [BPB-1:0][CW-1:0] rd_addr,
  output logic [BPB-1:0][7:0]    rd_data,
  output logic [CW-1:0]          cnt,
  output logic [CW-1:0]          cnt_nxt
);

  logic [7:0]    mem_q [MAX_PIXELS];
  logic [7:0]    mem_d [MAX_PIXELS];
  logic [CW-1:0] cnt_q, cnt_d;
  int            nbytes;

  always_comb begin
    nbytes = 0;
    for (int k = 0; k < BPB; k++) nbytes += int'(wr_keep[k]);
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (we) begin
      for (int k = 0; k < BPB; k++)
        if (k < nbytes && int'(cnt_q) + k < MAX_PIXELS)
          mem_d[AW'(int'(cnt_q) + k)] = wr_data[8*k +: 8];
      cnt_d = (int'(cnt_q) + nbytes > MAX_PIXELS) ? CW'(MAX_PIXELS) : CW'(int'(cnt_q) + nbytes);
    end
  end

  // Reading the next-state image lets the final B beat feed the first output beat.
  always_comb begin
    for (int k = 0; k < BPB; k++)
      rd_data[k] = (rd_addr[k] < CW'(MAX_PIXELS)) ? mem_d[AW'(rd_addr[k])] : 8'h00;
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt     = cnt_q;
  assign cnt_nxt = cnt_d;

endmodule

// File: rtl/tensor_to_bitmap_reshaper.sv
// Buffers R, G, B planes from one stream and emits a single interleaved RGB packet.
// Optional length check: define TENSOR_TO_BITMAP_LENGTH_CHECK_EN.
module tensor_to_bitmap_reshaper
  import tensor_to_bitmap_reshaper_pkg::*;
#(
  parameter int TDATA_WIDTH = 256,
  parameter int TUSER_WIDTH = 128,
  parameter int MAX_PIXELS  = 256
) (
  input  logic                        axis_aclk,
  input  logic                        axis_reset,
  tensor_to_bitmap_reshaper_if.slave  axis_input,
  tensor_to_bitmap_reshaper_if.master axis_output,
  output logic                        plane_error
);

  localparam int TKEEP_WIDTH = TDATA_WIDTH / 8;
  localparam int BPB = TKEEP_WIDTH;
  localparam int CW  = cnt_w(MAX_PIXELS);
  localparam int BW  = byte_cnt_w(MAX_PIXELS);

`ifdef TENSOR_TO_BITMAP_LENGTH_CHECK_EN
  localparam bit LEN_CHECK = 1'b1;
`else
  localparam bit LEN_CHECK = 1'b0;
`endif

  state_e                  state_q, state_d;
  logic                    rdy_q, rdy_d;
  logic                    first_q, first_d;
  logic                    drop_q, drop_d;
  logic                    err_q, err_d;
  logic [TUSER_WIDTH-1:0]  user_q, user_d;
  logic [BW-1:0]           emit_cnt_q, emit_cnt_d;
  logic [TDATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic [TKEEP_WIDTH-1:0]  out_keep_q, out_keep_d;
  logic [TUSER_WIDTH-1:0]  out_user_q, out_user_d;
  logic                    out_vld_q, out_vld_d;
  logic                    out_last_q, out_last_d;

  logic [NUM_CH-1:0]                   we;
  logic                                clr;
  logic [NUM_CH-1:0][CW-1:0]           cnt, cnt_nxt;
  logic [NUM_CH-1:0][BPB-1:0][7:0]     rd_data;
  logic [BPB-1:0][CW-1:0]              rd_addr;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_plane
    tensor_plane_buffer #(.BPB(BPB), .MAX_PIXELS(MAX_PIXELS)) u_buf (
      .clk    (axis_aclk),
      .rst    (axis_reset),
      .we     (we[ch]),
      .clr    (clr),
      .wr_data(axis_input.tdata),
      .wr_keep(axis_input.tkeep),
      .rd_addr(rd_addr),
      .rd_data(rd_data[ch]),
      .cnt    (cnt[ch]),
      .cnt_nxt(cnt_nxt[ch])
    );
  end

  // Next output beat: byte i = base+k is pixel i/3, channel i%3.
  int                     base, total;
  logic [TDATA_WIDTH-1:0] nxt_data;
  logic [TKEEP_WIDTH-1:0] nxt_keep;
  logic                   nxt_last;
  logic [BW-1:0]          nxt_cnt;

  always_comb begin
    base     = (state_q == EMIT) ? int'(emit_cnt_q) : 0;
    total    = 3 * int'(cnt[CH_R]);
    nxt_data = '0;
    nxt_keep = '0;
    rd_addr  = '0;
    for (int k = 0; k < BPB; k++) begin
      rd_addr[k] = CW'((base + k) / 3);
      if (base + k < total) begin
        nxt_keep[k]        = 1'b1;
        nxt_data[8*k +: 8] = rd_data[2'((base + k) % 3)][k];
      end
    end
    nxt_last = (base + BPB >= total);
    nxt_cnt  = nxt_last ? BW'(total) : BW'(base + BPB);
  end

  logic hs_in, hs_out, g_mism, b_mism;
  assign hs_in  = axis_input.tvalid && rdy_q;
  assign hs_out = out_vld_q && axis_output.tready;
  assign g_mism = LEN_CHECK && (cnt_nxt[CH_G] != cnt[CH_R]);
  assign b_mism = LEN_CHECK && (drop_q || cnt_nxt[CH_B] != cnt[CH_R]);

  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    drop_d     = drop_q;
    err_d      = err_q;
    user_d     = user_q;
    emit_cnt_d = emit_cnt_q;
    out_data_d = out_data_q;
    out_keep_d = out_keep_q;
    out_user_d = out_user_q;
    out_vld_d  = out_vld_q;
    out_last_d = out_last_q;
    we         = '0;
    clr        = 1'b0;
    case (state_q)
      LOAD_R: if (hs_in) begin
        we[CH_R] = 1'b1;
        if (first_q) begin
          user_d  = axis_input.tuser;
          first_d = 1'b0;
        end
        if (axis_input.tlast) state_d = LOAD_G;
      end
      LOAD_G: if (hs_in) begin
        we[CH_G] = 1'b1;
        if (axis_input.tlast) begin
          state_d = LOAD_B;
          // Keep consuming B so the stream stays plane-aligned; drop at its tlast.
          if (g_mism) begin
            drop_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      LOAD_B: if (hs_in) begin
        we[CH_B] = 1'b1;
        if (axis_input.tlast) begin
          if (b_mism) err_d = 1'b1;
          if (b_mism || cnt[CH_R] == '0) begin
            clr     = 1'b1;
            state_d = LOAD_R;
            first_d = 1'b1;
            drop_d  = 1'b0;
          end else begin
            state_d    = EMIT;
            out_vld_d  = 1'b1;
            out_data_d = nxt_data;
            out_keep_d = nxt_keep;
            out_last_d = nxt_last;
            out_user_d = user_q;
            emit_cnt_d = nxt_cnt;
          end
        end
      end
      EMIT: if (hs_out) begin
        if (out_last_q) begin
          clr        = 1'b1;
          state_d    = LOAD_R;
          first_d    = 1'b1;
          out_vld_d  = 1'b0;
          out_last_d = 1'b0;
          out_keep_d = '0;
          out_data_d = '0;
          emit_cnt_d = '0;
        end else begin
          out_data_d = nxt_data;
          out_keep_d = nxt_keep;
          out_last_d = nxt_last;
          emit_cnt_d = nxt_cnt;
        end
      end
      default: state_d = LOAD_R;
    endcase
    rdy_d = (state_d != EMIT);
  end

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      state_q    <= LOAD_R;
      rdy_q      <= 1'b0;
      first_q    <= 1'b1;
      drop_q     <= 1'b0;
      err_q      <= 1'b0;
      user_q     <= '0;
      emit_cnt_q <= '0;
      out_data_q <= '0;
      out_keep_q <= '0;
      out_user_q <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= rdy_d;
      first_q    <= first_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
      user_q     <= user_d;
      emit_cnt_q <= emit_cnt_d;
      out_data_q <= out_data_d;
      out_keep_q <= out_keep_d;
      out_user_q <= out_user_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
    end
  end

  assign axis_input.tready  = rdy_q;
  assign axis_output.tdata  = out_data_q;
  assign axis_output.tkeep  = out_keep_q;
  assign axis_output.tuser  = out_user_q;
  assign axis_output.tvalid = out_vld_q;
  assign axis_output.tlast  = out_last_q;
  assign plane_error        = err_q;

endmodule
